// File: rtl/rv32_ctrl_defs.sv
// Shared control definitions for the RV32I forwarding/hazard logic.
package rv32_ctrl_defs;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned FWD_W  = 2;

    typedef logic [FWD_W-1:0] fwd_sel_t;

    // Select encoding shared with the 3:1 operand forwarding mux; 2'b11 is never driven.
    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_WB  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;

endpackage

// File: rtl/fwd_hazard_unit_fwd_select.sv
// Forwarding select for one ALU operand, from the EX instruction's source tag
// and the EX/MEM and MEM/WB destination tags.
module fwd_select #(
    parameter int unsigned REG_AW = rv32_ctrl_defs::REG_AW
) (
    input  logic                     idex_valid,
    input  logic [REG_AW-1:0]        src_reg,
    input  logic                     src_used,
    input  logic                     exmem_valid,
    input  logic [REG_AW-1:0]        exmem_rd,
    input  logic                     exmem_regwrite,
    input  logic                     exmem_memread,
    input  logic                     memwb_valid,
    input  logic [REG_AW-1:0]        memwb_rd,
    input  logic                     memwb_regwrite,
    output rv32_ctrl_defs::fwd_sel_t sel
);

    import rv32_ctrl_defs::FWD_RF;
    import rv32_ctrl_defs::FWD_WB;
    import rv32_ctrl_defs::FWD_MEM;

    logic needs_fwd;
    logic exmem_hit;
    logic memwb_hit;

    // EX/MEM wins over MEM/WB because it carries the newer value of the register.
    // A load in EX/MEM has no data on the ALU-result path yet; the load-use stall
    // guarantees no consumer ever sits right behind it, so excluding it is free.
    always_comb begin
        needs_fwd = idex_valid & src_used & (src_reg != '0);
        exmem_hit = exmem_valid & exmem_regwrite & ~exmem_memread & (exmem_rd == src_reg);
        memwb_hit = memwb_valid & memwb_regwrite & (memwb_rd == src_reg);
        sel       = FWD_RF;
        if (needs_fwd && exmem_hit) begin
            sel = FWD_MEM;
        end else if (needs_fwd && memwb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding selects and load-use stall control for the RV32I pipeline.
// Keeps a shadow copy of the register-usage tags in ID/EX, EX/MEM and MEM/WB.
module fwd_hazard_unit #(
    parameter int unsigned REG_AW = rv32_ctrl_defs::REG_AW,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic [REG_AW-1:0]        id_rs1,
    input  logic [REG_AW-1:0]        id_rs2,
    input  logic                     id_use_rs1,
    input  logic                     id_use_rs2,
    input  logic [REG_AW-1:0]        id_rd,
    input  logic                     id_regwrite,
    input  logic                     id_memread,
    input  logic                     flush,
    output rv32_ctrl_defs::fwd_sel_t forward_a,
    output rv32_ctrl_defs::fwd_sel_t forward_b,
    output logic                     stall,
    output logic [CNT_W-1:0]         stall_count
);

    // ID/EX shadow slot
    logic              idex_valid;
    logic [REG_AW-1:0] idex_rs1;
    logic [REG_AW-1:0] idex_rs2;
    logic              idex_use1;
    logic              idex_use2;
    logic [REG_AW-1:0] idex_rd;
    logic              idex_regwrite;
    logic              idex_memread;

    // EX/MEM shadow slot
    logic              exmem_valid;
    logic [REG_AW-1:0] exmem_rd;
    logic              exmem_regwrite;
    logic              exmem_memread;

    // MEM/WB shadow slot
    logic              memwb_valid;
    logic [REG_AW-1:0] memwb_rd;
    logic              memwb_regwrite;

    logic              load_in_ex;
    logic              id_reads_load;
    logic              bubble;

    // Load-use detection: a load in EX whose rd is read by the instruction in ID.
    // A flush kills the ID instruction, so it never stalls.
    always_comb begin
        load_in_ex    = idex_valid & idex_memread & idex_regwrite & (idex_rd != '0);
        id_reads_load = (id_use_rs1 & (id_rs1 == idex_rd)) |
                        (id_use_rs2 & (id_rs2 == idex_rd));
        stall         = load_in_ex & id_valid & id_reads_load & ~flush;
        bubble        = stall | flush | ~id_valid;
    end

    // Advance the tag pipeline; stall or flush turns the ID/EX entry into a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_valid     <= 1'b0;
            idex_rs1       <= '0;
            idex_rs2       <= '0;
            idex_use1      <= 1'b0;
            idex_use2      <= 1'b0;
            idex_rd        <= '0;
            idex_regwrite  <= 1'b0;
            idex_memread   <= 1'b0;
            exmem_valid    <= 1'b0;
            exmem_rd       <= '0;
            exmem_regwrite <= 1'b0;
            exmem_memread  <= 1'b0;
            memwb_valid    <= 1'b0;
            memwb_rd       <= '0;
            memwb_regwrite <= 1'b0;
        end else begin
            memwb_valid    <= exmem_valid;
            memwb_rd       <= exmem_rd;
            memwb_regwrite <= exmem_regwrite;

            exmem_valid    <= idex_valid;
            exmem_rd       <= idex_rd;
            exmem_regwrite <= idex_regwrite;
            exmem_memread  <= idex_memread;

            idex_valid     <= ~bubble;
            idex_rs1       <= id_rs1;
            idex_rs2       <= id_rs2;
            idex_use1      <= id_use_rs1;
            idex_use2      <= id_use_rs2;
            idex_rd        <= id_rd;
            idex_regwrite  <= id_regwrite & ~bubble;
            idex_memread   <= id_memread & ~bubble;
        end
    end

    // Saturating stall-cycle counter for performance monitoring.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

    fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
        .idex_valid     (idex_valid),
        .src_reg        (idex_rs1),
        .src_used       (idex_use1),
        .exmem_valid    (exmem_valid),
        .exmem_rd       (exmem_rd),
        .exmem_regwrite (exmem_regwrite),
        .exmem_memread  (exmem_memread),
        .memwb_valid    (memwb_valid),
        .memwb_rd       (memwb_rd),
        .memwb_regwrite (memwb_regwrite),
        .sel            (forward_a)
    );

    fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
        .idex_valid     (idex_valid),
        .src_reg        (idex_rs2),
        .src_used       (idex_use2),
        .exmem_valid    (exmem_valid),
        .exmem_rd       (exmem_rd),
        .exmem_regwrite (exmem_regwrite),
        .exmem_memread  (exmem_memread),
        .memwb_valid    (memwb_valid),
        .memwb_rd       (memwb_rd),
        .memwb_regwrite (memwb_regwrite),
        .sel            (forward_b)
    );

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed vector table, hand-written
// reset / saturation sequences, and randomized traffic against an in-order
// pipeline reference model.
module tb_fwd_hazard_unit;

    localparam int unsigned AW     = 5;
    localparam int unsigned CW     = 4;
    localparam int          CNTMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [AW-1:0] id_rs1;
    logic [AW-1:0] id_rs2;
    logic          id_use_rs1;
    logic          id_use_rs2;
    logic [AW-1:0] id_rd;
    logic          id_regwrite;
    logic          id_memread;
    logic          flush;
    logic [1:0]    forward_a;
    logic [1:0]    forward_b;
    logic          stall;
    logic [CW-1:0] stall_count;

    int checks   = 0;
    int failures = 0;

    fwd_hazard_unit #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .flush       (flush),
        .forward_a   (forward_a),
        .forward_b   (forward_b),
        .stall       (stall),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic          u1;
        logic          u2;
        logic [AW-1:0] rd;
        logic          rw;
        logic          mr;
    } instr_t;

    typedef struct {
        instr_t        ins;
        logic          fl;
        logic [1:0]    fa;
        logic [1:0]    fb;
        logic          st;
        logic [CW-1:0] cnt;
    } vec_t;

    // Reference model: instructions in EX (0), MEM (1), WB (2) plus the stall tally.
    instr_t pipe [3];
    int     mcnt;
    instr_t cur_i;
    logic   cur_fl;

    function automatic instr_t mk(input logic v, input int rs1, input int rs2,
                                  input logic u1, input logic u2, input int rd,
                                  input logic rw, input logic mr);
        instr_t i;
        i.v = v; i.rs1 = AW'(rs1); i.rs2 = AW'(rs2); i.u1 = u1; i.u2 = u2;
        i.rd = AW'(rd); i.rw = rw; i.mr = mr;
        return i;
    endfunction

    function automatic instr_t nop();
        return mk(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endfunction

    function automatic instr_t add(input int rd, input int rs1, input int rs2);
        return mk(1'b1, rs1, rs2, 1'b1, 1'b1, rd, 1'b1, 1'b0);
    endfunction

    function automatic instr_t lw(input int rd, input int rs1);
        return mk(1'b1, rs1, 0, 1'b1, 1'b0, rd, 1'b1, 1'b1);
    endfunction

    function automatic vec_t vv(input instr_t i, input logic fl, input logic [1:0] fa,
                                input logic [1:0] fb, input logic st, input int cnt);
        vec_t v;
        v.ins = i; v.fl = fl; v.fa = fa; v.fb = fb; v.st = st; v.cnt = CW'(cnt);
        return v;
    endfunction

    function automatic logic writes(input instr_t s, input logic [AW-1:0] r);
        return s.v && s.rw && (s.rd == r) && (r != 0);
    endfunction

    // Newest in-flight producer of the EX operand: MEM stage -> 10, WB stage -> 01.
    function automatic logic [1:0] exp_sel(input logic [AW-1:0] r, input logic used);
        if (!pipe[0].v || !used) return 2'b00;
        for (int age = 1; age <= 2; age++) begin
            if (writes(pipe[age], r)) return (age == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic logic exp_stall(input instr_t i, input logic fl);
        if (fl || !i.v) return 1'b0;
        if (!(pipe[0].v && pipe[0].mr && pipe[0].rw && pipe[0].rd != 0)) return 1'b0;
        return (i.u1 && i.rs1 == pipe[0].rd) || (i.u2 && i.rs2 == pipe[0].rd);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) pipe[k] = nop();
        mcnt = 0;
    endtask

    task automatic apply(input instr_t i, input logic fl);
        cur_i       = i;
        cur_fl      = fl;
        id_valid    = i.v;
        id_rs1      = i.rs1;
        id_rs2      = i.rs2;
        id_use_rs1  = i.u1;
        id_use_rs2  = i.u2;
        id_rd       = i.rd;
        id_regwrite = i.rw;
        id_memread  = i.mr;
        flush       = fl;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_fa"},  32'(forward_a),   32'(exp_sel(pipe[0].rs1, pipe[0].u1)));
        chk({tag, "_fb"},  32'(forward_b),   32'(exp_sel(pipe[0].rs2, pipe[0].u2)));
        chk({tag, "_st"},  32'(stall),       32'(exp_stall(cur_i, cur_fl)));
        chk({tag, "_cnt"}, 32'(stall_count), 32'(mcnt));
    endtask

    // Clock edge: model shifts its stages exactly as the pipeline would.
    task automatic advance();
        logic   st;
        instr_t nxt;
        st  = exp_stall(cur_i, cur_fl);
        nxt = cur_i;
        if (!cur_i.v || st || cur_fl) begin
            nxt.v = 1'b0; nxt.rw = 1'b0; nxt.mr = 1'b0;
        end
        @(posedge clk);
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = nxt;
        if (st && mcnt < CNTMAX) mcnt++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply(nop(), 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    vec_t vecs [24];

    initial begin
        vecs[0]  = vv(add(5, 1, 2),   1'b0, 2'b00, 2'b00, 1'b0, 0);
        vecs[1]  = vv(add(6, 5, 5),   1'b0, 2'b00, 2'b00, 1'b0, 0);
        vecs[2]  = vv(nop(),          1'b0, 2'b10, 2'b10, 1'b0, 0);
        vecs[3]  = vv(add(10, 11, 12),1'b0, 2'b00, 2'b00, 1'b0, 0);
        vecs[4]  = vv(nop(),          1'b0, 2'b00, 2'b00, 1'b0, 0);
        vecs[5]  = vv(add(13, 10, 10),1'b0, 2'b00, 2'b00, 1'b0, 0);
        vecs[6]  = vv(nop(),          1'b0, 2'b01, 2'b01, 1'b0, 0);
        vecs[7]  = vv(add(5, 1, 2),   1'b0, 2'b00, 2'b00, 1'b0, 0);
        vecs[8]  = vv(add(5, 3, 4),   1'b0, 2'b00, 2'b00, 1'b0, 0);
        vecs[9]  = vv(add(14, 5, 0),  1'b0, 2'b00, 2'b00, 1'b0, 0);
        vecs[10] = vv(nop(),          1'b0, 2'b10, 2'b00, 1'b0, 0);
        vecs[11] = vv(lw(7, 2),       1'b0, 2'b00, 2'b00, 1'b0, 0);
        vecs[12] = vv(add(8, 7, 1),   1'b0, 2'b00, 2'b00, 1'b1, 0);
        vecs[13] = vv(add(8, 7, 1),   1'b0, 2'b00, 2'b00, 1'b0, 1);
        vecs[14] = vv(nop(),          1'b0, 2'b01, 2'b00, 1'b0, 1);
        vecs[15] = vv(lw(0, 1),       1'b0, 2'b00, 2'b00, 1'b0, 1);
        vecs[16] = vv(add(1, 0, 0),   1'b0, 2'b00, 2'b00, 1'b0, 1);
        vecs[17] = vv(lw(3, 2),       1'b0, 2'b00, 2'b00, 1'b0, 1);
        vecs[18] = vv(mk(1'b1, 3, 3, 1'b0, 1'b0, 3, 1'b1, 1'b0),
                                      1'b0, 2'b00, 2'b00, 1'b0, 1);
        vecs[19] = vv(nop(),          1'b0, 2'b00, 2'b00, 1'b0, 1);
        vecs[20] = vv(lw(7, 2),       1'b0, 2'b00, 2'b00, 1'b0, 1);
        vecs[21] = vv(add(8, 7, 7),   1'b1, 2'b00, 2'b00, 1'b0, 1);
        vecs[22] = vv(nop(),          1'b0, 2'b00, 2'b00, 1'b0, 1);
        vecs[23] = vv(nop(),          1'b0, 2'b00, 2'b00, 1'b0, 1);

        model_reset();
        do_reset();

        // Directed vector table.
        for (int n = 0; n < 24; n++) begin
            apply(vecs[n].ins, vecs[n].fl);
            #3;
            chk($sformatf("vec%0d_fa", n),  32'(forward_a),   32'(vecs[n].fa));
            chk($sformatf("vec%0d_fb", n),  32'(forward_b),   32'(vecs[n].fb));
            chk($sformatf("vec%0d_st", n),  32'(stall),       32'(vecs[n].st));
            chk($sformatf("vec%0d_cnt", n), 32'(stall_count), 32'(vecs[n].cnt));
            chk_model($sformatf("vec%0d_model", n));
            advance();
        end

        // Asynchronous reset while EX/MEM writes x5 and a load-use stall is live.
        apply(add(5, 1, 2), 1'b0); #3; advance();
        apply(lw(7, 5), 1'b0);     #3; advance();
        apply(add(8, 7, 1), 1'b0); #3;
        chk("prerst_fa", 32'(forward_a), 32'(2'b10));
        chk("prerst_st", 32'(stall),     32'(1'b1));
        rst = 1'b1;
        #1;
        chk("rst_fa",  32'(forward_a),   32'(2'b00));
        chk("rst_fb",  32'(forward_b),   32'(2'b00));
        chk("rst_st",  32'(stall),       32'(1'b0));
        chk("rst_cnt", 32'(stall_count), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        apply(add(9, 5, 5), 1'b0); #3;
        chk("postrst_fa", 32'(forward_a), 32'(2'b00));
        chk("postrst_st", 32'(stall),     32'(1'b0));
        advance();
        apply(nop(), 1'b0); #3;
        chk("postrst2_fa", 32'(forward_a), 32'(2'b00));
        chk("postrst2_fb", 32'(forward_b), 32'(2'b00));
        advance();

        // Counter saturation: alternate load / dependent reader, one stall per pair.
        do_reset();
        for (int j = 0; j < 18; j++) begin
            apply(lw(7, 1), 1'b0); #3;
            chk($sformatf("sat%0d_cnt", j), 32'(stall_count), 32'((j > CNTMAX) ? CNTMAX : j));
            advance();
            apply(add(8, 7, 7), 1'b0); #3;
            chk($sformatf("sat%0d_st", j), 32'(stall), 32'(1'b1));
            advance();
        end
        apply(nop(), 1'b0); #3;
        chk("sat_final_cnt", 32'(stall_count), 32'(CNTMAX));
        advance();

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            instr_t r;
            logic   fl;
            logic   rw;
            rw = 1'($urandom_range(0, 1));
            r  = mk(($urandom_range(0, 9) != 0), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                    rw, rw & 1'($urandom_range(0, 1)));
            fl = ($urandom_range(0, 7) == 0);
            apply(r, fl);
            #3;
            chk_model($sformatf("rnd%0d", c));
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Control end of the EX-stage operand-forwarding muxes. It generates the 2-bit selects that drive the 3:1 forwarding muxes on ALU operands A and B.
- Keeps its own shadow pipeline (ID/EX, EX/MEM, MEM/WB) of register-usage tags and detects load-use hazards.
- Issues an IF/ID stall plus an ID/EX bubble on a load-use hazard, and counts stall cycles for performance monitoring.
- Sits beside the RV32I datapath and is fed from decode and branch resolution.

Parameters:
- REG_AW, 5, register-address width (x0..x31).
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs1  input  REG_AW  source register 1 of the ID instruction.
- id_rs2  input  REG_AW  source register 2 of the ID instruction.
- id_use_rs1  input  1  ID instruction reads rs1.
- id_use_rs2  input  1  ID instruction reads rs2.
- id_rd  input  REG_AW  destination register of the ID instruction.
- id_regwrite  input  1  ID instruction writes rd.
- id_memread  input  1  ID instruction is a load.
- flush  input  1  taken branch/jump resolved in EX; kill IF/ID and ID/EX.
- forward_a  output  2  mux select for ALU operand A.
- forward_b  output  2  mux select for ALU operand B.
- stall  output  1  hold PC and IF/ID; insert bubble into ID/EX.
- stall_count  output  CNT_W  saturating count of stall cycles.

Behaviour:
- Decided: one clock; reset is asynchronous and active-high. Ports are clk and rst.
- Select encoding (shared with the 3:1 forwarding mux):
  - 00 = register-file value.
  - 01 = MEM/WB write-back result.
  - 10 = EX/MEM ALU result.
  - 11 is never driven.
- Shadow slots:
  - IDEX holds {valid, rs1, rs2, use1, use2, rd, regwrite, memread}.
  - EXMEM holds {valid, rd, regwrite, memread}.
  - MEMWB holds {valid, rd, regwrite}.
- Every rising edge:
  - EXMEM <= IDEX fields.
  - MEMWB <= EXMEM fields.
  - IDEX <= ID inputs, with valid = id_valid & ~stall & ~flush.
  - When stall or flush is active, IDEX becomes a bubble: valid = 0, regwrite = 0, memread = 0.
- A slot "writes r" iff valid & regwrite & rd == r & rd != 0.
- forward_a (combinational from registered slots; forward_b is identical using rs2/use2):
  - If IDEX is valid, use1 = 1 and EXMEM writes IDEX.rs1 -> 10.
  - Else if MEMWB writes IDEX.rs1 -> 01.
  - Else -> 00.
  - EXMEM has priority because it holds the newer value.
  - Invalid IDEX -> 00.
- stall (combinational):
  - Asserts when IDEX is valid, IDEX.memread, IDEX.regwrite, IDEX.rd != 0, and (id_use_rs1 & id_rs1 == IDEX.rd) or (id_use_rs2 & id_rs2 == IDEX.rd), all with id_valid = 1.
  - Duration is exactly one cycle per load-use pair. On the next cycle the load sits in EXMEM, IDEX is a bubble, stall drops, and the instruction then forwards from MEMWB (01) once in EX.
- flush dominates stall:
  - stall = 0 while flush = 1.
  - IDEX is bubbled. EXMEM and MEMWB advance normally.
- Register file is write-before-read within a cycle, so there is no ID-stage bypass.
- stall_count increments by 1 on each cycle stall = 1 and saturates at all-ones (no wrap).
- Reset (async, immediate):
  - All slot valid/regwrite/memread bits = 0.
  - forward_a = forward_b = 00, stall = 0, stall_count = 0.
  - Reset mid-operation discards all in-flight tags. The first post-reset cycle forwards nothing.
- x0 is never forwarded and never causes a stall.

Decomposition:
- Shared package/header `rv32_ctrl_defs`:
  - FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - REG_AW.
- One natural sub-module, `fwd_select`: purely combinational. Takes IDEX rs/use plus the EXMEM and MEMWB tags, outputs one 2-bit select. Instantiate it twice (A and B).

Test Plan:
- Reset: assert rst mid-stream with EXMEM writing x5 -> forward_a/b = 00, stall = 0, stall_count = 0 immediately (before any clk edge).
- EX-EX forward: add x5 then add x6,x5,x5 back-to-back -> second instr in EX gives forward_a = 10, forward_b = 10. With one intervening nop -> 01/01.
- Double hazard priority: x5 written by instr N and N+1, read by N+2 -> forward_a = 10 (not 01).
- Load-use: lw x7 then add x8,x7,x1 -> stall = 1 for exactly one cycle, then add reaches EX with forward_a = 01, forward_b = 00, and stall_count = 1.
- x0 / unused source:
  - lw x0 followed by a reader of x0 -> stall = 0, selects 00.
  - lw x3 followed by lui x3 (use_rs1 = 0) -> stall = 0.
- Flush vs stall:
  - lw x7, reader of x7, with flush = 1 in the same cycle -> stall = 0, IDEX bubbled, stall_count unchanged.
  - Preload stall_count to all-ones-1 and run 3 stall cycles -> counter holds at all-ones.
